// File: rtl/mix_mem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : mix_mem_arbiter_if
// Description : CPU, I/O channel and RAM bundle for the MIX memory arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
interface mix_mem_arbiter_if #(
    parameter int AW = 12,
    parameter int DW = 31
);
    logic          cpu_req;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic          cpu_ack;
    logic          cpu_err;
    logic [DW-1:0] cpu_rdata;

    logic          io_req;
    logic          io_we;
    logic [AW-1:0] io_addr;
    logic [DW-1:0] io_wdata;
    logic          io_ack;
    logic          io_err;
    logic [DW-1:0] io_rdata;
    logic          io_lock;

    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    logic          busy;
    logic          grant_io;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  io_req, io_we, io_addr, io_wdata, io_lock,
        input  mem_rdata,
        output cpu_ack, cpu_err, cpu_rdata,
        output io_ack, io_err, io_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata,
        output busy, grant_io
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output io_req, io_we, io_addr, io_wdata, io_lock,
        output mem_rdata,
        input  cpu_ack, cpu_err, cpu_rdata,
        input  io_ack, io_err, io_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        input  busy, grant_io
    );
endinterface
`default_nettype wire

// File: rtl/mix_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mix_mem_arbiter
// Description : Round-robin CPU / I/O arbiter for the MIX main-memory port.
//               Optional I/O burst lock enabled by defining MIX_IO_BURST_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module mix_mem_arbiter #(
    parameter int MEM_WORDS = 4000,
    parameter int AW        = 12,
    parameter int DW        = 31,
    parameter int BURST_MAX = 100
) (
    input  wire logic        clk_in,
    input  wire logic        reset,
    mix_mem_arbiter_if.slave bus
);
    localparam logic [1:0]  c_S_IDLE    = 2'd0;
    localparam logic [1:0]  c_S_ISSUE   = 2'd1;
    localparam logic [1:0]  c_S_DONE    = 2'd2;
    localparam logic [AW:0] c_MEM_WORDS = (AW+1)'(MEM_WORDS);

    logic [1:0]    r_state;
    logic [1:0]    w_nextState;
    logic          r_lastIo;
    logic          r_memEn;
    logic          r_memWe;
    logic [AW-1:0] r_memAddr;
    logic [DW-1:0] r_memWdata;
    logic          r_grantIo;
    logic          r_err;
    logic          r_we;

    logic          w_anyReq;
    logic          w_pickIo;
    logic          w_we;
    logic [AW-1:0] w_addr;
    logic [DW-1:0] w_wdata;
    logic          w_inRange;
    logic          w_grantNow;
    logic          w_done;
    logic          w_rdValid;

    assign w_anyReq   = bus.cpu_req | bus.io_req;
    assign w_grantNow = (r_state == c_S_IDLE) && w_anyReq;

`ifdef MIX_IO_BURST_EN
    localparam int c_CNT_W = $clog2(BURST_MAX + 1);
    logic [c_CNT_W-1:0] r_burstCnt;
    logic               w_forceCpu;

    assign w_forceCpu = (r_burstCnt == c_CNT_W'(BURST_MAX)) && bus.cpu_req;

    always_comb begin
        w_pickIo = bus.io_req;
        if (bus.cpu_req && bus.io_req)
            w_pickIo = w_forceCpu ? 1'b0 : ~r_lastIo;
    end

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset)
            r_burstCnt <= '0;
        else if (!bus.io_lock)
            r_burstCnt <= '0;
        else if (w_grantNow) begin
            if (!w_pickIo)
                r_burstCnt <= '0;
            else if (r_burstCnt != c_CNT_W'(BURST_MAX))
                r_burstCnt <= r_burstCnt + 1'b1;
        end
    end

    // A locked I/O grant leaves the pointer on CPU so ties keep going to I/O
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset)
            r_lastIo <= 1'b1;
        else if (w_grantNow && !(w_pickIo && bus.io_lock))
            r_lastIo <= w_pickIo;
    end
`else
    logic w_unusedLock;
    assign w_unusedLock = bus.io_lock;

    always_comb begin
        w_pickIo = bus.io_req;
        if (bus.cpu_req && bus.io_req)
            w_pickIo = ~r_lastIo;
    end

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset)
            r_lastIo <= 1'b1;
        else if (w_grantNow)
            r_lastIo <= w_pickIo;
    end
`endif

    assign w_we      = w_pickIo ? bus.io_we    : bus.cpu_we;
    assign w_addr    = w_pickIo ? bus.io_addr  : bus.cpu_addr;
    assign w_wdata   = w_pickIo ? bus.io_wdata : bus.cpu_wdata;
    assign w_inRange = {1'b0, w_addr} < c_MEM_WORDS;

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset)
            r_state <= c_S_IDLE;
        else
            r_state <= w_nextState;
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            c_S_IDLE:  if (w_anyReq) w_nextState = c_S_ISSUE;
            c_S_ISSUE: w_nextState = c_S_DONE;
            c_S_DONE:  w_nextState = c_S_IDLE;
            default:   w_nextState = c_S_IDLE;
        endcase
    end

    // Access fields are latched once in IDLE; later input changes are ignored
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            r_memEn    <= 1'b0;
            r_memWe    <= 1'b0;
            r_memAddr  <= '0;
            r_memWdata <= '0;
            r_grantIo  <= 1'b0;
            r_err      <= 1'b0;
            r_we       <= 1'b0;
        end else if (w_grantNow) begin
            r_memEn    <= w_inRange;
            r_memWe    <= w_we & w_inRange;
            r_memAddr  <= w_addr;
            r_memWdata <= w_wdata;
            r_grantIo  <= w_pickIo;
            r_err      <= ~w_inRange;
            r_we       <= w_we;
        end else if (r_state == c_S_ISSUE) begin
            r_memEn <= 1'b0;
            r_memWe <= 1'b0;
        end
    end

    assign w_done    = (r_state == c_S_DONE);
    assign w_rdValid = w_done & ~r_err & ~r_we;

    always_comb begin
        bus.busy      = (r_state != c_S_IDLE);
        bus.grant_io  = r_grantIo;
        bus.mem_en    = r_memEn;
        bus.mem_we    = r_memWe;
        bus.mem_addr  = r_memAddr;
        bus.mem_wdata = r_memWdata;
        bus.cpu_ack   = w_done & ~r_grantIo;
        bus.io_ack    = w_done & r_grantIo;
        bus.cpu_err   = w_done & ~r_grantIo & r_err;
        bus.io_err    = w_done & r_grantIo & r_err;
        bus.cpu_rdata = (w_rdValid && !r_grantIo) ? bus.mem_rdata : '0;
        bus.io_rdata  = (w_rdValid && r_grantIo) ? bus.mem_rdata : '0;
    end
endmodule
`default_nettype wire

// File: doc/mix_mem_arbiter.md
Name: mix_mem_arbiter

Overview:
- Arbitrates the single MIX main-memory port (MEM_WORDS words × 31 bits: sign + five 6-bit bytes) between two requesters: the CPU and the I/O channel that serves IN/OUT block transfers.
- Sequences every access through a small FSM, drives the synchronous RAM (1-cycle read latency), and returns ack/rdata/err to the winner.
- Sits between the CPU core, the I/O unit and the block RAM inside the mix top level.

Parameters:
- MEM_WORDS, 4000, number of valid word addresses (0..MEM_WORDS-1)
- AW, 12, address width
- DW, 31, word width (sign bit 30, bytes 29:0)
- BURST_MAX, 100, max consecutive I/O grants under burst lock (one MIX tape block)

Ports:
- clk_in  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- cpu_req  in  1  CPU access request; held until cpu_ack
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  AW  word address
- cpu_wdata  in  DW  write data
- cpu_ack  out  1  one-cycle completion pulse
- cpu_err  out  1  valid with cpu_ack; address out of range
- cpu_rdata  out  DW  read data, valid while cpu_ack=1
- io_req, io_we, io_addr, io_wdata, io_ack, io_err, io_rdata: same as the cpu_* ports, for the I/O channel
- io_lock  in  1  burst-lock request (used only with MIX_IO_BURST_EN)
- mem_en  out  1  RAM enable
- mem_we  out  1  RAM write enable
- mem_addr  out  AW  RAM address
- mem_wdata  out  DW  RAM write data
- mem_rdata  in  DW  RAM read data, valid the cycle after the sampling edge
- busy  out  1  1 when state != IDLE
- grant_io  out  1  1 while the current access belongs to I/O

Behaviour:
- Reset (async): state=IDLE; mem_en, mem_we, mem_addr, mem_wdata, cpu_ack, io_ack, cpu_err, io_err, busy and grant_io all 0; RR pointer last=IO, so the CPU wins the first tie; burst counter=0.
- FSM states: IDLE, ISSUE, DONE.
- IDLE:
  - Sample the requests. If none, stay.
  - Otherwise pick the winner, register mem_addr/mem_we/mem_wdata from the winner, set grant_io, and go to ISSUE.
  - mem_en=1 only when addr < MEM_WORDS.
  - Out-of-range access: mem_en=0 and mem_we=0, flag err internally.
- ISSUE: the RAM samples the registered address/control at the end of this cycle. Clear mem_en and mem_we at that edge. Go to DONE.
- DONE:
  - Winner's ack=1 for exactly one cycle; winner's err = out-of-range flag.
  - Winner's rdata = mem_rdata (passthrough) for a valid read; 0 for a write or an error.
  - Loser's ack=0; loser's rdata=0. Go to IDLE.
- Latency: req seen in IDLE at cycle 0 → ack in cycle 2. Minimum spacing of accesses is 3 cycles.
- Requester rule: at the edge ending its ack cycle, a requester either drops req or presents a new access. The arbiter samples only in IDLE, so a stale req is never double-served.
- Arbitration:
  - Only one request present: grant it.
  - Both present: grant the side that is not `last`, then update `last` to the winner.
  - Requests arriving in ISSUE or DONE wait; no request is ever lost while held.
- Write: RAM is written exactly once, in ISSUE. Inputs changing after IDLE do not affect the access, because the values are latched.
- Simultaneous reset during ISSUE: mem_we clears asynchronously, so no RAM write completes and no ack is issued.
- No starvation: with both requesters saturated, grants strictly alternate (without burst).

Optional Feature:
- Macro: MIX_IO_BURST_EN.
- Enabled:
  - If io_lock=1 when I/O wins, `last` is not updated on I/O grants. Subsequent ties go to I/O while io_lock stays 1.
  - A burst counter increments per I/O grant. When it reaches BURST_MAX and cpu_req=1, the CPU is forced to win once; the counter then clears.
  - The counter clears whenever io_lock=0 or the CPU is granted.
- Disabled: io_lock is ignored, no counter is synthesised, and arbitration is pure round-robin.

Test Plan:
- Reset, then CPU write addr 10 data 31'o12345670123, then CPU read addr 10 → each ack 2 cycles after its req is sampled; read rdata=31'o12345670123, err=0; mem_we high in exactly one cycle.
- cpu_req and io_req both asserted in the same cycle, back to back for 6 accesses → grant order CPU, IO, CPU, IO, CPU, IO; acks never overlap.
- IO read addr 4000 and 4095 → io_ack with io_err=1, io_rdata=0, mem_en never asserted; a following read of addr 3999 gives err=0.
- Reset pulsed during ISSUE of a CPU write to addr 20 (old value 5) → no ack; later read of addr 20 returns 5; all outputs 0 during reset.
- Single requester, IO only, 10 reads addrs 0..9 → 10 acks at 3-cycle spacing, data matches preload, grant_io=1 throughout.
- With MIX_IO_BURST_EN, io_lock=1 and BURST_MAX=4, both saturated → grants IO×4, CPU, IO×4, CPU. Without the macro, the same stimulus gives strict alternation.
